// File: rtl/dmem_wait.sv
// Data memory with req/ready handshake, WAIT_CYC wait states, byte-lane writes
// and an out-of-range flag; stall freezes the pipeline until ready pulses.
module dmem_wait #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int DEPTH    = 64,
   parameter int WAIT_CYC = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wd,
   output logic [DATA_W-1:0]     rd,
   output logic                  ready,
   output logic                  stall,
   output logic                  err,
   output logic [1:0]            dbg_state
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int NB    = DATA_W / 8;
   localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic                r_we;
   logic [NB-1:0]       r_be;
   logic [IDX_W-1:0]    r_idx;
   logic [DATA_W-1:0]   r_wd;
   logic                r_oor;
   logic [DATA_W-1:0]   r_rd;
   logic                r_ready;
   logic                r_err;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic [IDX_W-1:0]    w_idx;
   logic                w_oor;
   logic [IDX_W-1:0]    w_rd_idx;
   logic                w_rd_oor;
   logic                w_finish;
   logic                w_unused;

   assign w_idx    = addr[IDX_W+1:2];
   assign w_oor    = (addr >> (IDX_W + 2)) != '0;
   assign w_unused = ^addr[1:0];

   // With no wait states the read happens on the accept edge, straight from the inputs.
   assign w_rd_idx = (WAIT_CYC == 0) ? w_idx : r_idx;
   assign w_rd_oor = (WAIT_CYC == 0) ? w_oor : r_oor;
   assign w_finish = ((r_state == IDLE) && req && (WAIT_CYC == 0)) ||
                     ((r_state == BUSY) && (r_cnt == 4'd0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_idx   <= '0;
         r_wd    <= '0;
         r_oor   <= 1'b0;
         r_rd    <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         if (w_finish) begin
            r_state <= DONE;
            r_ready <= 1'b1;
            r_err   <= w_rd_oor;
            r_rd    <= w_rd_oor ? '0 : r_mem[w_rd_idx];
         end
         case (r_state)
            IDLE: begin
               if (req) begin
                  r_we  <= we;
                  r_be  <= be;
                  r_idx <= w_idx;
                  r_wd  <= wd;
                  r_oor <= w_oor;
                  r_cnt <= CNT_INIT;
                  if (WAIT_CYC != 0) r_state <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // RAM is never reset; the write lands on the edge that ends DONE.
   always_ff @(posedge clk) begin
      if ((r_state == DONE) && r_we && !r_oor) begin
         for (int i = 0; i < NB; i++) begin
            if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wd[8*i +: 8];
         end
      end
   end

   assign rd        = r_rd;
   assign ready     = r_ready;
   assign err       = r_err;
   assign stall     = req & ~r_ready;
   assign dbg_state = r_state;

endmodule
